cmd_encode: RTL

Command encoder and initiator for the 8-byte USB-JTAG command protocol. It accepts one parallel command request, serializes it onto the byte-wide RXD interface of the command decoder, and collects the decoder's 0/1/2-byte reply from the TXD interface. It returns the reply as one 16-bit result. It lets on-chip logic (self-test, autonomous sequencers) drive LED, 7-SEG, VGA, FLASH, SDRAM and SRAM targets without a host PC.

---
 rtl/cmd_encode_pkg.sv | 52 +++++
 rtl/cmd_rsp_capture.sv | 70 +++++++
 rtl/cmd_encode.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cmd_encode_pkg.sv
// Shared command codes, request payload layout and byte-order helper for the
// USB-JTAG command encoder.
package cmd_encode_pkg;

  localparam int unsigned CMD_BYTES = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned TMO_W     = 20;

  // Action codes
  localparam logic [7:0] ACT_SETUP = 8'h61;
  localparam logic [7:0] ACT_ERASE = 8'h72;
  localparam logic [7:0] ACT_WRITE = 8'h83;
  localparam logic [7:0] ACT_READ  = 8'h94;

  // Target codes
  localparam logic [7:0] TGT_LED   = 8'hF0;
  localparam logic [7:0] TGT_SEG7  = 8'hE1;
  localparam logic [7:0] TGT_FLASH = 8'hC3;
  localparam logic [7:0] TGT_SDRAM = 8'hB4;
  localparam logic [7:0] TGT_SRAM  = 8'hA5;
  localparam logic [7:0] TGT_VGA   = 8'h87;

  // Mode codes
  localparam logic [7:0] MODE_NORMAL  = 8'h00;
  localparam logic [7:0] MODE_DISPLAY = 8'hFF;
  localparam logic [7:0] MODE_OUTSEL  = 8'h33;

  typedef struct packed {
    logic [7:0]  action;
    logic [7:0]  target;
    logic [23:0] addr;
    logic [15:0] data;
    logic [7:0]  mode;
  } cmd_req_t;

  // Wire order of the 8 command bytes, first to last.
  function automatic logic [7:0] cmd_byte(input cmd_req_t r, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = r.action;
      3'd1:    b = r.target;
      3'd2:    b = r.addr[23:16];
      3'd3:    b = r.addr[15:8];
      3'd4:    b = r.addr[7:0];
      3'd5:    b = r.data[15:8];
      3'd6:    b = r.data[7:0];
      default: b = r.mode;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cmd_rsp_capture.sv
// Reply-byte handshake: armed flag, one-cycle TXD acknowledge, received-byte
// count and per-byte timeout counter.
module cmd_rsp_capture
  import cmd_encode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txd_start,
  input  logic       collect,
  input  logic       tmo_run,
  input  logic       cnt_clr,
  output logic       txd_done,
  output logic       byte_valid_c,
  output logic       timeout_c,
  output logic [1:0] rcv_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic             armed_q, armed_d;
  logic             done_q, done_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             capture_c;

  assign capture_c    = txd_start & armed_q;
  assign byte_valid_c = capture_c & collect;
  assign timeout_c    = tmo_run & ~byte_valid_c & (tmo_q == TMO_LAST);

  always_comb begin
    armed_d = armed_q;
    done_d  = capture_c;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    // Re-arm only once Start is seen low outside the acknowledge cycle.
    if (capture_c) begin
      armed_d = 1'b0;
    end else if (!txd_start && !done_q) begin
      armed_d = 1'b1;
    end
    if (cnt_clr) begin
      cnt_d = 2'd0;
    end else if (byte_valid_c) begin
      cnt_d = cnt_q + 2'd1;
    end
    if (tmo_run && !byte_valid_c) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= 2'd0;
      tmo_q   <= '0;
    end else begin
      armed_q <= armed_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign txd_done = done_q;
  assign rcv_cnt  = cnt_q;

endmodule

// File: rtl/cmd_encode.sv
// Command encoder: serializes one parallel request into 8 RXD bytes and
// assembles the decoder's 0/1/2-byte reply into a 16-bit result.
module cmd_encode
  import cmd_encode_pkg::*;
#(
  parameter int unsigned BYTE_GAP    = 3,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iREQ_Valid,
  output logic        oREQ_Ready,
  input  logic [7:0]  iREQ_Action,
  input  logic [7:0]  iREQ_Target,
  input  logic [23:0] iREQ_ADDR,
  input  logic [15:0] iREQ_DATA,
  input  logic [7:0]  iREQ_MODE,
  input  logic [1:0]  iRSP_Bytes,
  output logic [7:0]  oRXD_DATA,
  output logic        oRXD_Ready,
  input  logic [7:0]  iTXD_DATA,
  input  logic        iTXD_Start,
  output logic        oTXD_Done,
  output logic [15:0] oRSP_DATA,
  output logic        oRSP_Valid,
  output logic        oRSP_Err
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_GAP, ST_WAIT_RSP, ST_RESP} state_t;

  localparam logic [7:0]       GAP_LAST = 8'((BYTE_GAP == 0) ? 0 : BYTE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_BYTES - 1);

  state_t           state_q, state_d;
  cmd_req_t         req_q, req_d, req_in;
  logic [1:0]       exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       rxd_data_q, rxd_data_d;
  logic             rxd_ready_q, rxd_ready_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             accept_c, collect_c, tmo_run_c, byte_valid_c, timeout_c;
  logic [1:0]       rcv_cnt;

  assign req_in    = '{action: iREQ_Action, target: iREQ_Target, addr: iREQ_ADDR,
                       data: iREQ_DATA, mode: iREQ_MODE};
  assign accept_c  = (state_q == ST_IDLE) && iREQ_Valid;
  assign tmo_run_c = (state_q == ST_WAIT_RSP);
  assign collect_c = tmo_run_c && (rcv_cnt != exp_q);

  cmd_rsp_capture #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_capture (
    .clk          (iCLK),
    .rst_n        (iRST_n),
    .txd_start    (iTXD_Start),
    .collect      (collect_c),
    .tmo_run      (tmo_run_c),
    .cnt_clr      (accept_c),
    .txd_done     (oTXD_Done),
    .byte_valid_c (byte_valid_c),
    .timeout_c    (timeout_c),
    .rcv_cnt      (rcv_cnt)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    rxd_data_d  = rxd_data_q;
    rxd_ready_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;

    if (byte_valid_c) begin
      if (rcv_cnt == 2'd0) rsp_data_d[7:0]  = iTXD_DATA;
      else                 rsp_data_d[15:8] = iTXD_DATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d       = req_in;
          exp_d       = (iRSP_Bytes == 2'd3) ? 2'd2 : iRSP_Bytes;
          idx_d       = '0;
          rxd_data_d  = cmd_byte(req_in, '0);
          rxd_ready_d = 1'b1;
          rsp_data_d  = 16'h0000;
          rsp_err_d   = 1'b0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (idx_q == IDX_LAST) begin
          // Write-only commands complete right after the last byte.
          if (exp_q == 2'd0) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end else if (BYTE_GAP == 0) begin
          idx_d       = idx_q + IDX_W'(1);
          rxd_data_d  = cmd_byte(req_q, idx_q + IDX_W'(1));
          rxd_ready_d = 1'b1;
        end else begin
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          idx_d       = idx_q + IDX_W'(1);
          rxd_data_d  = cmd_byte(req_q, idx_q + IDX_W'(1));
          rxd_ready_d = 1'b1;
          state_d     = ST_SEND;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_WAIT_RSP: begin
        if (rcv_cnt == exp_q) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_c) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      exp_q       <= 2'd0;
      idx_q       <= '0;
      gap_q       <= 8'd0;
      rxd_data_q  <= 8'h00;
      rxd_ready_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      rxd_data_q  <= rxd_data_d;
      rxd_ready_q <= rxd_ready_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign oREQ_Ready = (state_q == ST_IDLE);
  assign oRXD_DATA  = rxd_data_q;
  assign oRXD_Ready = rxd_ready_q;
  assign oRSP_DATA  = rsp_data_q;
  assign oRSP_Valid = rsp_valid_q;
  assign oRSP_Err   = rsp_err_q;

endmodule
